init_seq: RTL and testbench
===========================

INIT_SEQ -- requirements
Module: init_seq

Interface
REQ-001 The block SHALL have parameter LOCK_FILT, default 64, the number of consecutive pll_lock-high cycles required before sequencing starts (range 1..2^16).
REQ-002 The block SHALL have parameter STAGE_DLY, default 1000, the cycles between successive stage-reset releases (range 1..2^32-1).
REQ-003 The block SHALL have parameter CAL_TMO, default 1000000, the cycles allowed for cal_done after the last stage release (range 1..2^32-1).
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset, driven by the upstream long power-on reset stage.
REQ-006 The block SHALL have port pll_lock, input, 1 bit: PLL lock indicator, already synchronous to clk.
REQ-007 The block SHALL have port cal_done, input, 1 bit: level, high when downstream calibration is complete.
REQ-008 The block SHALL have port rst_out, output, 4 bits: per-stage active-high resets; bit i is released before bit i+1.
REQ-009 The block SHALL have port ready, output, 1 bit: high only in state RUN.
REQ-010 The block SHALL have port fault, output, 1 bit: high only in state FAULT; sticky.
REQ-011 The block SHALL have port st, output, 3 bits: current state code.
REQ-012 The block SHALL have port lost_cnt, output, 8 bits: lock-loss event count, saturating at 255.

Function
REQ-013 All outputs SHALL be registered; no combinational path from any input to any output.
REQ-014 The state codes SHALL be IDLE=0, WAIT_LOCK=1, RELEASE=2, WAIT_CAL=3, RUN=4, FAULT=5; codes 6..7 SHALL go to IDLE on the next edge.
REQ-015 IDLE SHALL go to WAIT_LOCK on the first edge with rst=0; rst_out stays 4'b1111.
REQ-016 In WAIT_LOCK, a filter counter SHALL increment on each edge with pll_lock=1 and clear to 0 on any edge with pll_lock=0.
REQ-017 WAIT_LOCK SHALL go to RELEASE on the edge that samples the LOCK_FILT-th consecutive pll_lock=1; the stage index and delay counter are cleared on entry.
REQ-018 In RELEASE, the delay counter SHALL count edges; on the STAGE_DLY-th edge after entry or after the previous release, rst_out[index] clears, index increments and the counter clears.
REQ-019 On the edge that clears rst_out[3], the state SHALL go to WAIT_CAL with the timeout counter at 0; rst_out is then 4'b0000.
REQ-020 In WAIT_CAL, cal_done=1 SHALL move the state to RUN with ready=1 on that edge; otherwise the timeout counter increments.
REQ-021 WAIT_CAL SHALL go to FAULT on the CAL_TMO-th edge without cal_done: fault=1, rst_out=4'b1111, ready=0.
REQ-022 If cal_done=1 on the same edge as the timeout, RUN SHALL take priority over FAULT.
REQ-023 pll_lock=0 in RELEASE, WAIT_CAL or RUN SHALL, on that edge: set rst_out=4'b1111, ready=0, move to WAIT_LOCK, clear all counters, and increment lost_cnt (saturating at 255).
REQ-024 Lock loss SHALL take priority over cal_done and over timeout on the same edge.
REQ-025 FAULT SHALL be left only by rst; pll_lock and cal_done SHALL be ignored in FAULT.
REQ-026 Changes of cal_done in RUN SHALL have no effect.
REQ-027 Counters SHALL be 32 bits wide and SHALL never wrap; each counter clears at its terminal count.

Reset
REQ-028 rst=1 SHALL, on the next edge and from any state (including mid-RELEASE or FAULT), set st=IDLE, rst_out=4'b1111, ready=0, fault=0, lost_cnt=0 and all internal counters to 0.
REQ-029 Power-up register values SHALL equal the reset values.

Verification (LOCK_FILT=3, STAGE_DLY=4, CAL_TMO=10)
REQ-030 Nominal run: drop rst, pll_lock=1 -> st=2 after 3 lock samples; rst_out goes 1110, 1100, 1000, 0000 at 4-edge spacing; assert cal_done -> st=4 and ready=1 on the sampling edge.
REQ-031 Lock glitch in filter: pll_lock 1,1,0,1,1,1 -> filter restarts; RELEASE is entered only after the final three highs.
REQ-032 Lock loss with rst_out=1100 -> next edge rst_out=1111, st=1, lost_cnt=1; relock -> full sequence repeats; 300 losses -> lost_cnt=255.
REQ-033 Cal timeout: cal_done held 0 -> st=5, fault=1, rst_out=1111 on the 10th WAIT_CAL edge; cal_done then 1 -> no change; rst=1 -> st=0, fault=0.
REQ-034 Simultaneous events: cal_done=1 on the 10th edge -> st=4; pll_lock=0 together with cal_done=1 -> st=1, ready=0.
REQ-035 Reset mid-RELEASE with rst_out=1000 -> next edge rst_out=1111, st=0, all counters 0.

Source files
------------

// File: rtl/init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : init_seq
//  Description : Power-up initialisation sequencer. Filters PLL lock, releases
//                four stage resets in order with a fixed spacing, waits for
//                downstream calibration with a timeout, and tracks lock-loss
//                events. All outputs are registered.
//  Revision    : 1.0 - initial release
// ============================================================================
module init_seq #(
    parameter int unsigned LOCK_FILT = 64,
    parameter int unsigned STAGE_DLY = 1000,
    parameter int unsigned CAL_TMO   = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       cal_done,
    output logic [3:0] rst_out,
    output logic       ready,
    output logic       fault,
    output logic [2:0] st,
    output logic [7:0] lost_cnt
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        RELEASE   = 3'd2,
        WAIT_CAL  = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    // Terminal values: each counter clears on the edge it would reach its limit.
    localparam logic [31:0] c_LOCK_LAST  = 32'(LOCK_FILT - 1);
    localparam logic [31:0] c_STAGE_LAST = 32'(STAGE_DLY - 1);
    localparam logic [31:0] c_CAL_LAST   = 32'(CAL_TMO - 1);
    localparam logic [3:0]  c_ALL_RESET  = 4'b1111;
    localparam logic [7:0]  c_LOST_MAX   = 8'hFF;

    state_t      r_state,     w_state_nxt;
    logic [31:0] r_filt_cnt,  w_filt_cnt_nxt;
    logic [31:0] r_dly_cnt,   w_dly_cnt_nxt;
    logic [31:0] r_tmo_cnt,   w_tmo_cnt_nxt;
    logic [1:0]  r_idx,       w_idx_nxt;
    logic [3:0]  r_rst_out,   w_rst_out_nxt;
    logic        r_ready,     w_ready_nxt;
    logic        r_fault,     w_fault_nxt;
    logic [7:0]  r_lost_cnt,  w_lost_cnt_nxt;
    logic        w_lock_lost;

    // State, counters and all outputs are registered together.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_filt_cnt <= '0;
            r_dly_cnt  <= '0;
            r_tmo_cnt  <= '0;
            r_idx      <= '0;
            r_rst_out  <= c_ALL_RESET;
            r_ready    <= 1'b0;
            r_fault    <= 1'b0;
            r_lost_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_filt_cnt <= w_filt_cnt_nxt;
            r_dly_cnt  <= w_dly_cnt_nxt;
            r_tmo_cnt  <= w_tmo_cnt_nxt;
            r_idx      <= w_idx_nxt;
            r_rst_out  <= w_rst_out_nxt;
            r_ready    <= w_ready_nxt;
            r_fault    <= w_fault_nxt;
            r_lost_cnt <= w_lost_cnt_nxt;
        end
    end

    // Next-state and next-output logic; lock loss overrides the state's own decision.
    always_comb begin
        w_state_nxt    = r_state;
        w_filt_cnt_nxt = r_filt_cnt;
        w_dly_cnt_nxt  = r_dly_cnt;
        w_tmo_cnt_nxt  = r_tmo_cnt;
        w_idx_nxt      = r_idx;
        w_rst_out_nxt  = r_rst_out;
        w_ready_nxt    = r_ready;
        w_fault_nxt    = r_fault;
        w_lost_cnt_nxt = r_lost_cnt;
        w_lock_lost    = 1'b0;

        case (r_state)
            IDLE: begin
                w_state_nxt    = WAIT_LOCK;
                w_rst_out_nxt  = c_ALL_RESET;
                w_ready_nxt    = 1'b0;
                w_fault_nxt    = 1'b0;
                w_filt_cnt_nxt = '0;
                w_dly_cnt_nxt  = '0;
                w_tmo_cnt_nxt  = '0;
                w_idx_nxt      = '0;
            end

            WAIT_LOCK: begin
                if (pll_lock) begin
                    if (r_filt_cnt == c_LOCK_LAST) begin
                        w_state_nxt    = RELEASE;
                        w_filt_cnt_nxt = '0;
                        w_dly_cnt_nxt  = '0;
                        w_idx_nxt      = '0;
                    end else begin
                        w_filt_cnt_nxt = r_filt_cnt + 32'd1;
                    end
                end else begin
                    // Any low sample restarts the consecutive-lock window.
                    w_filt_cnt_nxt = '0;
                end
            end

            RELEASE: begin
                if (!pll_lock) begin
                    w_lock_lost = 1'b1;
                end else if (r_dly_cnt == c_STAGE_LAST) begin
                    w_rst_out_nxt[r_idx] = 1'b0;
                    w_dly_cnt_nxt        = '0;
                    w_idx_nxt            = r_idx + 2'd1;
                    if (r_idx == 2'd3) begin
                        w_state_nxt   = WAIT_CAL;
                        w_tmo_cnt_nxt = '0;
                    end
                end else begin
                    w_dly_cnt_nxt = r_dly_cnt + 32'd1;
                end
            end

            WAIT_CAL: begin
                if (!pll_lock) begin
                    w_lock_lost = 1'b1;
                end else if (cal_done) begin
                    // Completion wins over a timeout landing on the same edge.
                    w_state_nxt   = RUN;
                    w_ready_nxt   = 1'b1;
                    w_tmo_cnt_nxt = '0;
                end else if (r_tmo_cnt == c_CAL_LAST) begin
                    w_state_nxt   = FAULT;
                    w_fault_nxt   = 1'b1;
                    w_ready_nxt   = 1'b0;
                    w_rst_out_nxt = c_ALL_RESET;
                    w_tmo_cnt_nxt = '0;
                end else begin
                    w_tmo_cnt_nxt = r_tmo_cnt + 32'd1;
                end
            end

            RUN: begin
                // cal_done is deliberately ignored once running.
                if (!pll_lock) begin
                    w_lock_lost = 1'b1;
                end
            end

            FAULT: begin
                // Sticky: only rst leaves this state.
                w_state_nxt = FAULT;
            end

            default: begin
                w_state_nxt    = IDLE;
                w_rst_out_nxt  = c_ALL_RESET;
                w_ready_nxt    = 1'b0;
                w_fault_nxt    = 1'b0;
                w_filt_cnt_nxt = '0;
                w_dly_cnt_nxt  = '0;
                w_tmo_cnt_nxt  = '0;
                w_idx_nxt      = '0;
            end
        endcase

        if (w_lock_lost) begin
            w_state_nxt    = WAIT_LOCK;
            w_rst_out_nxt  = c_ALL_RESET;
            w_ready_nxt    = 1'b0;
            w_filt_cnt_nxt = '0;
            w_dly_cnt_nxt  = '0;
            w_tmo_cnt_nxt  = '0;
            w_idx_nxt      = '0;
            w_lost_cnt_nxt = (r_lost_cnt == c_LOST_MAX) ? r_lost_cnt
                                                        : r_lost_cnt + 8'd1;
        end
    end

    assign rst_out  = r_rst_out;
    assign ready    = r_ready;
    assign fault    = r_fault;
    assign st       = r_state;
    assign lost_cnt = r_lost_cnt;

endmodule
`default_nettype wire

// File: tb/tb_init_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_init_seq
//  Description : Directed self-checking bench for init_seq with
//                LOCK_FILT=3, STAGE_DLY=4, CAL_TMO=10.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_init_seq;

    logic       clk;
    logic       rst;
    logic       pll_lock;
    logic       cal_done;
    logic [3:0] rst_out;
    logic       ready;
    logic       fault;
    logic [2:0] st;
    logic [7:0] lost_cnt;

    int errors = 0;
    int checks = 0;

    // Expected lost_cnt, maintained by the directed sequence.
    logic [7:0] e_lc = 8'd0;

    // Packed expectation: {st, rst_out, ready, fault, lost_cnt}
    logic [16:0] sb[$];

    init_seq #(
        .LOCK_FILT(3),
        .STAGE_DLY(4),
        .CAL_TMO  (10)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .pll_lock(pll_lock),
        .cal_done(cal_done),
        .rst_out (rst_out),
        .ready   (ready),
        .fault   (fault),
        .st      (st),
        .lost_cnt(lost_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one edge worth of inputs, queue the expected result, then check it.
    task automatic step(input string tag, input logic r, input logic l, input logic c,
                        input logic [2:0] est, input logic [3:0] ero,
                        input logic erdy, input logic eflt);
        logic [16:0] exp_v;
        logic [16:0] obs_v;
        rst      = r;
        pll_lock = l;
        cal_done = c;
        sb.push_back({est, ero, erdy, eflt, e_lc});
        @(posedge clk);
        #1;
        obs_v = {st, rst_out, ready, fault, lost_cnt};
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s: scoreboard empty, observed=%h", tag, obs_v);
        end else begin
            exp_v = sb.pop_front();
            assert (obs_v === exp_v) else begin
                errors++;
                $error("FAIL %s: observed st=%0d rst_out=%b rdy=%b flt=%b lost=%0d expected st=%0d rst_out=%b rdy=%b flt=%b lost=%0d",
                       tag, obs_v[16:14], obs_v[13:10], obs_v[9], obs_v[8], obs_v[7:0],
                       exp_v[16:14], exp_v[13:10], exp_v[9], exp_v[8], exp_v[7:0]);
            end
        end
    endtask

    // From WAIT_LOCK: three lock samples enter RELEASE on the third.
    task automatic lock_filter();
        step("filt", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("filt", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("filt_enter", 1'b0, 1'b1, 1'b0, 3'd2, 4'b1111, 1'b0, 1'b0);
    endtask

    // From RELEASE entry: release n stages, one every fourth edge.
    task automatic release_stages(input int n);
        logic [3:0] ro;
        ro = 4'b1111;
        for (int s = 0; s < n; s++) begin
            for (int k = 0; k < 3; k++)
                step("rel_wait", 1'b0, 1'b1, 1'b0, 3'd2, ro, 1'b0, 1'b0);
            ro[s] = 1'b0;
            step("rel_edge", 1'b0, 1'b1, 1'b0, (s == 3) ? 3'd3 : 3'd2, ro, 1'b0, 1'b0);
        end
    endtask

    // From IDLE (after reset): full path into WAIT_CAL.
    task automatic start_to_cal();
        step("idle_exit", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        lock_filter();
        release_stages(4);
    endtask

    initial begin
        rst      = 1'b1;
        pll_lock = 1'b0;
        cal_done = 1'b0;

        // Reset state
        step("reset", 1'b1, 1'b0, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0);
        step("reset_hold", 1'b1, 1'b1, 1'b1, 3'd0, 4'b1111, 1'b0, 1'b0);

        // Nominal sequence, calibration completes early
        start_to_cal();
        for (int k = 0; k < 3; k++)
            step("cal_wait", 1'b0, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0);
        step("cal_done", 1'b0, 1'b1, 1'b1, 3'd4, 4'b0000, 1'b1, 1'b0);
        step("run_cal0", 1'b0, 1'b1, 1'b0, 3'd4, 4'b0000, 1'b1, 1'b0);
        step("run_cal1", 1'b0, 1'b1, 1'b1, 3'd4, 4'b0000, 1'b1, 1'b0);

        // Lock loss in RUN
        e_lc = 8'd1;
        step("loss_run", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);

        // Lock glitch inside the filter restarts it
        step("glitch1", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("glitch2", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("glitch0", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("glitch3", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("glitch4", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        step("glitch5", 1'b0, 1'b1, 1'b0, 3'd2, 4'b1111, 1'b0, 1'b0);

        // Lock loss with rst_out=1100, then relock repeats the full sequence
        release_stages(2);
        e_lc = 8'd2;
        step("loss_1100", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        lock_filter();
        release_stages(4);

        // cal_done on the timeout edge wins
        for (int k = 0; k < 9; k++)
            step("tmo_wait", 1'b0, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0);
        step("cal_at_tmo", 1'b0, 1'b1, 1'b1, 3'd4, 4'b0000, 1'b1, 1'b0);

        // Lock loss together with cal_done in WAIT_CAL
        e_lc = 8'd3;
        step("loss_run2", 1'b0, 1'b0, 1'b1, 3'd1, 4'b1111, 1'b0, 1'b0);
        lock_filter();
        release_stages(4);
        e_lc = 8'd4;
        step("loss_vs_cal", 1'b0, 1'b0, 1'b1, 3'd1, 4'b1111, 1'b0, 1'b0);

        // Lock loss on the timeout edge wins over FAULT
        lock_filter();
        release_stages(4);
        for (int k = 0; k < 9; k++)
            step("tmo_wait", 1'b0, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0);
        e_lc = 8'd5;
        step("loss_vs_tmo", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);

        // Calibration timeout -> FAULT, sticky against inputs
        lock_filter();
        release_stages(4);
        for (int k = 0; k < 9; k++)
            step("tmo_wait", 1'b0, 1'b1, 1'b0, 3'd3, 4'b0000, 1'b0, 1'b0);
        step("timeout", 1'b0, 1'b1, 1'b0, 3'd5, 4'b1111, 1'b0, 1'b1);
        step("flt_cal", 1'b0, 1'b1, 1'b1, 3'd5, 4'b1111, 1'b0, 1'b1);
        step("flt_lock0", 1'b0, 1'b0, 1'b1, 3'd5, 4'b1111, 1'b0, 1'b1);
        step("flt_lock0b", 1'b0, 1'b0, 1'b0, 3'd5, 4'b1111, 1'b0, 1'b1);
        step("flt_lock1", 1'b0, 1'b1, 1'b0, 3'd5, 4'b1111, 1'b0, 1'b1);
        e_lc = 8'd0;
        step("flt_rst", 1'b1, 1'b1, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0);

        // Reset mid-RELEASE at rst_out=1000; exact retiming proves counters cleared
        step("idle_exit", 1'b0, 1'b1, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        lock_filter();
        release_stages(3);
        step("rst_mid_rel", 1'b1, 1'b1, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0);
        start_to_cal();
        step("cal_done2", 1'b0, 1'b1, 1'b1, 3'd4, 4'b0000, 1'b1, 1'b0);

        // 300 lock losses saturate lost_cnt at 255
        e_lc = 8'd1;
        step("loss_run3", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        for (int n = 1; n < 300; n++) begin
            lock_filter();
            if (e_lc != 8'hFF) e_lc = e_lc + 8'd1;
            step("loss_sat", 1'b0, 1'b0, 1'b0, 3'd1, 4'b1111, 1'b0, 1'b0);
        end

        // Reset clears the saturated counter
        e_lc = 8'd0;
        step("final_rst", 1'b1, 1'b0, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
